// File: rtl/scan_chain_driver.sv
// Scan-chain master: shifts command bytes LSB-first into the memory bank chain.
// Define SCAN_READBACK_EN to also return the bits falling out of the chain as response bytes.

module scan_chain_driver #(
   parameter int CHAIN_LEN = 144,
   parameter int CNT_W     = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       busy,
   output logic       done,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [7:0] cmd_data,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_data,
   output logic       scan_enable,
   output logic       scan_data_out,
   input  logic       scan_data_in
);

   localparam int N_BYTES   = (CHAIN_LEN + 7) / 8;
   localparam int LAST_BITS = CHAIN_LEN - 8 * (N_BYTES - 1);

   localparam logic [CNT_W-1:0] LAST_BYTE     = CNT_W'(N_BYTES - 1);
   localparam logic [CNT_W-1:0] LAST_BIT_FULL = CNT_W'(7);
   localparam logic [CNT_W-1:0] LAST_BIT_TAIL = CNT_W'(LAST_BITS - 1);

   typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] byte_cnt;
   logic [CNT_W-1:0] bit_cnt;
   logic [CNT_W-1:0] bit_end;
   logic [7:0]       tx_sh;
   logic             cmd_fire;
   logic             shift_end;

   // The final byte may be a partial burst of LAST_BITS cycles.
   assign bit_end   = (byte_cnt == LAST_BYTE) ? LAST_BIT_TAIL : LAST_BIT_FULL;
   assign shift_end = (state == SHIFT) && (bit_cnt == bit_end);
   assign cmd_fire  = cmd_valid && cmd_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = FETCH;
         FETCH:   if (cmd_fire) state_nxt = SHIFT;
         SHIFT:   if (shift_end) state_nxt = (byte_cnt == LAST_BYTE) ? DONE : FETCH;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy          = (state != IDLE);
      done          = (state == DONE);
      scan_enable   = (state == SHIFT);
      scan_data_out = (state == SHIFT) && tx_sh[0];
`ifdef SCAN_READBACK_EN
      // Only take a new byte once the response register is free by the end of its burst.
      cmd_ready     = (state == FETCH) && (!rsp_valid || rsp_ready);
`else
      cmd_ready     = (state == FETCH);
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         byte_cnt <= '0;
         bit_cnt  <= '0;
      end else begin
         if (state == IDLE && start) byte_cnt <= '0;
         else if (shift_end)         byte_cnt <= byte_cnt + CNT_W'(1);
         if (cmd_fire)               bit_cnt  <= '0;
         else if (state == SHIFT)    bit_cnt  <= bit_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (cmd_fire)            tx_sh <= cmd_data;
      else if (state == SHIFT) tx_sh <= {1'b0, tx_sh[7:1]};
   end

`ifdef SCAN_READBACK_EN
   logic [7:0] rx_sh;
   logic [7:0] rx_nxt;

   always_comb begin
      rx_nxt                 = rx_sh;
      rx_nxt[bit_cnt[2:0]]   = scan_data_in;
   end

   always_ff @(posedge clk) begin
      if (cmd_fire)            rx_sh <= 8'h00;
      else if (state == SHIFT) rx_sh <= rx_nxt;
   end

   // A byte loading on the same edge as a consumer pop wins over the clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rsp_valid <= 1'b0;
         rsp_data  <= 8'h00;
      end else if (shift_end) begin
         rsp_valid <= 1'b1;
         rsp_data  <= rx_nxt;
      end else if (rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end
`else
   logic unused_readback;

   assign rsp_valid       = 1'b0;
   assign rsp_data        = 8'h00;
   assign unused_readback = &{1'b0, scan_data_in, rsp_ready};
`endif

endmodule

// File: tb/tb_scan_chain_driver.sv
// Directed bench for scan_chain_driver: a 144-bit and a 13-bit instance, each with a chain model.
// Response checks adapt to whether SCAN_READBACK_EN is defined.

module tb_scan_chain_driver;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   // 144-bit instance
   logic       start, cmd_valid, rsp_ready, scan_data_in;
   logic [7:0] cmd_data;
   logic       busy, done, cmd_ready, rsp_valid, scan_enable, scan_data_out;
   logic [7:0] rsp_data;

   // 13-bit instance
   logic       s_start, s_cmd_valid, s_rsp_ready, s_scan_data_in;
   logic [7:0] s_cmd_data;
   logic       s_busy, s_done, s_cmd_ready, s_rsp_valid, s_scan_enable, s_scan_data_out;
   logic [7:0] s_rsp_data;

   scan_chain_driver #(.CHAIN_LEN(144), .CNT_W(8)) u_dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .scan_enable(scan_enable), .scan_data_out(scan_data_out), .scan_data_in(scan_data_in)
   );

   scan_chain_driver #(.CHAIN_LEN(13), .CNT_W(4)) u_small (
      .clk(clk), .rst(rst), .start(s_start), .busy(s_busy), .done(s_done),
      .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready), .cmd_data(s_cmd_data),
      .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_data(s_rsp_data),
      .scan_enable(s_scan_enable), .scan_data_out(s_scan_data_out), .scan_data_in(s_scan_data_in)
   );

   // Chain models: bit 0 is the far end (next bit out), new bits enter at the top.
   logic [143:0] chain, preload_val;
   logic [12:0]  s_chain, s_preload_val;
   logic         preload_req, s_preload_req;

   assign scan_data_in   = chain[0];
   assign s_scan_data_in = s_chain[0];

   always @(posedge clk) begin
      if (preload_req)      chain <= preload_val;
      else if (scan_enable) chain <= {scan_data_out, chain[143:1]};
      if (s_preload_req)      s_chain <= s_preload_val;
      else if (s_scan_enable) s_chain <= {s_scan_data_out, s_chain[12:1]};
   end

   int         se_cnt, done_cnt, rsp_n, s_se_cnt, s_rsp_n;
   logic [7:0] rsp_q [0:31];
   logic [7:0] s_rsp_q [0:3];
   logic       mon_clr;

   always @(posedge clk) begin
      if (mon_clr) begin
         se_cnt <= 0; done_cnt <= 0; rsp_n <= 0; s_se_cnt <= 0; s_rsp_n <= 0;
      end else begin
         if (scan_enable) se_cnt <= se_cnt + 1;
         if (done) done_cnt <= done_cnt + 1;
         if (rsp_valid && rsp_ready && rsp_n < 32) begin
            rsp_q[rsp_n[4:0]] <= rsp_data;
            rsp_n <= rsp_n + 1;
         end
         if (s_scan_enable) s_se_cnt <= s_se_cnt + 1;
         if (s_rsp_valid && s_rsp_ready && s_rsp_n < 4) begin
            s_rsp_q[s_rsp_n[1:0]] <= s_rsp_data;
            s_rsp_n <= s_rsp_n + 1;
         end
      end
   end

   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [143:0] obs, input logic [143:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] d, output int blen);
      bit fired;
      fired = 1'b0;
      cmd_valid = 1'b1;
      cmd_data  = d;
      for (int i = 0; i < 100 && !fired; i++) begin
         if (cmd_ready) fired = 1'b1;
         tick();
      end
      cmd_valid = 1'b0;
      if (!fired) check("cmd_accept_timeout", 0, 1);
      blen = 0;
      while (scan_enable && blen < 32) begin
         blen++;
         tick();
      end
   endtask

   task automatic s_send_byte(input logic [7:0] d, output int blen);
      bit fired;
      fired = 1'b0;
      s_cmd_valid = 1'b1;
      s_cmd_data  = d;
      for (int i = 0; i < 100 && !fired; i++) begin
         if (s_cmd_ready) fired = 1'b1;
         tick();
      end
      s_cmd_valid = 1'b0;
      if (!fired) check("small_cmd_accept_timeout", 0, 1);
      blen = 0;
      while (s_scan_enable && blen < 32) begin
         blen++;
         tick();
      end
   endtask

   // Full 18-byte session: chain preloaded 0xA0..0xB1, command bytes 0x00..0x11.
   task automatic session(input string name, input int gap, input bit stall, input bit glitch);
      int           blen, bad, bad_stall;
      logic [143:0] exp_chain;
      bad = 0;
      bad_stall = 0;
      for (int k = 0; k < 18; k++) begin
         preload_val[8*k +: 8] = 8'(8'hA0 + k);
         exp_chain[8*k +: 8]   = 8'(k);
      end
      preload_req = 1'b1;
      mon_clr     = 1'b1;
      tick();
      preload_req = 1'b0;
      mon_clr     = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      check({name, "_busy_after_start"}, busy, 1);
      for (int b = 0; b < 18; b++) begin
         if (stall && b == 3) begin
            rsp_ready = 1'b0;
`ifdef SCAN_READBACK_EN
            cmd_valid = 1'b1;
            cmd_data  = 8'd3;
            repeat (20) begin
               if (cmd_ready || scan_enable || !rsp_valid || rsp_data != 8'hA2) bad_stall++;
               tick();
            end
`else
            repeat (20) begin
               if (!cmd_ready || scan_enable) bad_stall++;
               tick();
            end
`endif
            rsp_ready = 1'b1;
            check({name, "_stall_hold"}, bad_stall, 0);
         end
         if (glitch && b == 5) begin
            start = 1'b1;
            tick();
            start = 1'b0;
         end
         send_byte(8'(b), blen);
         if (blen != 8) bad++;
         if (b < 17) begin
            repeat (gap) begin
               if (scan_enable) bad++;
               tick();
            end
         end
      end
      check({name, "_done_pulse"}, done, 1);
      check({name, "_busy_at_done"}, busy, 1);
      tick();
      check({name, "_done_cleared"}, done, 0);
      check({name, "_busy_after_done"}, busy, 0);
      tick();
      check({name, "_burst_gap"}, bad, 0);
      check({name, "_scan_cycles"}, se_cnt, 144);
      check({name, "_done_count"}, done_cnt, 1);
      check({name, "_chain_after"}, chain, exp_chain);
`ifdef SCAN_READBACK_EN
      check({name, "_rsp_count"}, rsp_n, 18);
      for (int k = 0; k < 18; k++)
         check($sformatf("%s_rsp_byte%0d", name, k), rsp_q[k], 8'(8'hA0 + k));
      check({name, "_rsp_drained"}, rsp_valid, 0);
`else
      check({name, "_rsp_count"}, rsp_n, 0);
      check({name, "_rsp_data_tied"}, rsp_data, 0);
`endif
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int blen;
      rst = 1'b0;
      preload_req = 1'b0; s_preload_req = 1'b0; mon_clr = 1'b1;
      preload_val = '0; s_preload_val = '0;
      // Reset held with random inputs
      for (int i = 0; i < 6; i++) begin
         start = 1'($urandom_range(0, 1));  cmd_valid = 1'($urandom_range(0, 1));
         cmd_data = 8'($urandom);           rsp_ready = 1'($urandom_range(0, 1));
         s_start = 1'($urandom_range(0, 1)); s_cmd_valid = 1'($urandom_range(0, 1));
         s_cmd_data = 8'($urandom);          s_rsp_ready = 1'($urandom_range(0, 1));
         tick();
      end
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_cmd_ready", cmd_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_scan_enable", scan_enable, 0);
      check("rst_scan_data_out", scan_data_out, 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_small_outputs", {s_busy, s_done, s_cmd_ready, s_rsp_valid, s_scan_enable, s_scan_data_out, s_rsp_data}, 0);
      start = 1'b0; cmd_valid = 1'b0; cmd_data = 8'h00; rsp_ready = 1'b1;
      s_start = 1'b0; s_cmd_valid = 1'b0; s_cmd_data = 8'h00; s_rsp_ready = 1'b1;
      mon_clr = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      check("idle_busy", busy, 0);

      session("basic", 0, 1'b0, 1'b0);
      session("stall", 0, 1'b1, 1'b0);
      session("gap", 5, 1'b0, 1'b0);

      // Short chain: 13 bits, final burst of 5
      s_preload_val = 13'h0A5B;
      s_preload_req = 1'b1;
      mon_clr       = 1'b1;
      tick();
      s_preload_req = 1'b0;
      mon_clr       = 1'b0;
      s_start = 1'b1;
      tick();
      s_start = 1'b0;
      s_send_byte(8'hFF, blen);
      check("small_burst0_len", blen, 8);
      s_send_byte(8'h1F, blen);
      check("small_burst1_len", blen, 5);
      check("small_done", s_done, 1);
      tick();
      check("small_idle", s_busy, 0);
      tick();
      check("small_chain", s_chain, 13'h1FFF);
      check("small_scan_cycles", s_se_cnt, 13);
`ifdef SCAN_READBACK_EN
      check("small_rsp_count", s_rsp_n, 2);
      check("small_rsp0", s_rsp_q[0], 8'h5B);
      check("small_rsp1", s_rsp_q[1], 8'h0A);
`else
      check("small_rsp_count", s_rsp_n, 0);
`endif

      // Reset in the 4th cycle of a burst
      start = 1'b1;
      tick();
      start = 1'b0;
      cmd_valid = 1'b1;
      cmd_data  = 8'h5A;
      for (int i = 0; i < 20 && !cmd_ready; i++) tick();
      tick();
      cmd_valid = 1'b0;
      check("abort_in_shift", scan_enable, 1);
      tick();
      tick();
      tick();
      check("abort_4th_cycle", scan_enable, 1);
      rst = 1'b0;
      #1;
      check("abort_busy", busy, 0);
      check("abort_scan_enable", scan_enable, 0);
      check("abort_scan_data_out", scan_data_out, 0);
      check("abort_misc", {done, cmd_ready, rsp_valid, rsp_data}, 0);
      tick();
      rst = 1'b1;
      tick();
      session("after_abort", 0, 1'b0, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
